// File: rtl/aesl_deadlock_timeout_reporter.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_timeout_reporter
// Brief    : Aggregates the per-instance deadlock monitor block flags and
//            raises a sticky deadlock report once some monitor has been
//            blocked for THRESH consecutive cycles with no design progress.
//            Latches first blocked index, block vector and stall length for
//            the end-of-sim report.
// Revision : 1.0 - initial release
// ============================================================================
module aesl_deadlock_timeout_reporter #(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               progress,
  input  logic               clear,
  output logic               suspect,
  output logic               deadlock,
  output logic               deadlock_pulse,
  output logic [IDX_W-1:0]   first_idx,
  output logic [NUM_MON-1:0] block_snapshot,
  output logic [CNT_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SUSPECT  = 2'b01,
    ST_DEADLOCK = 2'b10
  } state_t;

  // Count value on the edge that completes the THRESH-th blocked sample
  localparam logic [CNT_W-1:0] C_LAST_CNT   = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] C_THRESH_CNT = CNT_W'(THRESH);

  state_t             r_state;
  logic               w_blk;
  logic [IDX_W-1:0]   w_low_idx;

  // A handshake in the same cycle means the design is still moving
  assign w_blk = (|mon_block) & ~progress;

  // Priority encoder: lowest-index monitor currently reporting a block
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (mon_block[i]) begin
        w_low_idx = IDX_W'(i);
      end
    end
  end

  // Stall-tracking FSM with all report outputs registered alongside the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      suspect        <= 1'b0;
      deadlock       <= 1'b0;
      deadlock_pulse <= 1'b0;
      first_idx      <= '0;
      block_snapshot <= '0;
      stall_cycles   <= '0;
    end else if (clear) begin
      r_state        <= ST_IDLE;
      suspect        <= 1'b0;
      deadlock       <= 1'b0;
      deadlock_pulse <= 1'b0;
      first_idx      <= '0;
      block_snapshot <= '0;
      stall_cycles   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          deadlock_pulse <= 1'b0;
          deadlock       <= 1'b0;
          if (w_blk) begin
            r_state      <= ST_SUSPECT;
            suspect      <= 1'b1;
            stall_cycles <= CNT_W'(1);
            first_idx    <= w_low_idx;
          end else begin
            suspect      <= 1'b0;
            stall_cycles <= '0;
          end
        end

        ST_SUSPECT: begin
          deadlock_pulse <= 1'b0;
          if (!w_blk) begin
            // Any unblocked cycle fully restarts the stall window
            r_state      <= ST_IDLE;
            suspect      <= 1'b0;
            stall_cycles <= '0;
            first_idx    <= '0;
          end else if (stall_cycles == C_LAST_CNT) begin
            r_state        <= ST_DEADLOCK;
            suspect        <= 1'b0;
            deadlock       <= 1'b1;
            deadlock_pulse <= 1'b1;
            stall_cycles   <= C_THRESH_CNT;
            block_snapshot <= mon_block;
          end else begin
            // first_idx is deliberately held: it names the stall's origin
            stall_cycles <= stall_cycles + CNT_W'(1);
          end
        end

        ST_DEADLOCK: begin
          // Report is frozen until clear or reset
          deadlock_pulse <= 1'b0;
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle state
          r_state        <= ST_IDLE;
          suspect        <= 1'b0;
          deadlock       <= 1'b0;
          deadlock_pulse <= 1'b0;
          first_idx      <= '0;
          block_snapshot <= '0;
          stall_cycles   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
